muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Multi-cycle HI/LO arithmetic responder for the execute stage. Execute issues a MULT/MULTU/DIV/DIVU/MTHI/MTLO request; this block computes the result, holds execute through the hazard unit while it runs, and owns the architectural HI/LO registers.
- It replaces the single-cycle multiply/divide path that is instantiated in execute.

Parameters:
- MUL_LAT, 2: cycles spent in the MUL state; range 1..4.
- DATA_W, 32: operand and HI/LO width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous active-high reset.
- valid_i  in  1  execute holds a valid muldiv-class instruction.
- op_i  in  4  md_op_t opcode.
- a_i  in  DATA_W  forwarded srca; dividend or multiplicand.
- b_i  in  DATA_W  forwarded srcb; divisor or multiplier.
- flush_i  in  1  exception or flush; abandons the operation.
- busy_o  out  1  stall request to the hazard unit.
- done_o  out  1  one-cycle pulse; the new HI/LO value is visible in this cycle.
- hi_o  out  DATA_W  architectural HI.
- lo_o  out  DATA_W  architectural LO.

Behaviour:
- Reset (asynchronous): state=IDLE, hi_o=0, lo_o=0, done_o=0, iteration counter=0. busy_o is forced to 0 while reset is high.
- FSM states: IDLE, MUL, DIV, FIX, DONE.
- Accept condition: state==IDLE && valid_i && !flush_i. Operands and op are latched on the accept edge. No accept happens in any other state.
- busy_o = (state==IDLE && valid_i && !flush_i && op is MULT/MULTU/DIV/DIVU[/MADD*]) || state in {MUL, DIV, FIX}.
  - busy_o is low in DONE, so execute advances on the DONE edge.
  - DONE always returns to IDLE and never re-accepts, so the same instruction is never issued twice.
  - A back-to-back muldiv instruction is accepted in the following IDLE cycle.
- MTHI/MTLO: written on the accept edge. No busy, no state change, done_o stays 0.
- MULT/MULTU: IDLE -> MUL for MUL_LAT cycles -> HI/LO written on the edge into DONE.
  - Result is the 64-bit signed or unsigned product; HI = upper 32 bits, LO = lower 32 bits.
  - Latency from accept edge to done_o: MUL_LAT+1 edges.
- DIV/DIVU: radix-2 restoring division on operand magnitudes.
  - 32 DIV cycles, counter 0..31, one quotient bit per cycle.
  - FIX state (1 cycle) applies signs: quotient is negated when the operand signs differ (signed op only); remainder takes the dividend's sign.
  - HI = remainder, LO = quotient, written on the edge into DONE.
  - busy_o is high for 34 cycles: the accept cycle, 32 DIV cycles and FIX.
- Divide by zero: no trap, same latency. LO = 0xFFFFFFFF, HI = dividend.
- Signed overflow 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- flush_i in MUL, DIV or FIX: state -> IDLE on the next edge, HI/LO unchanged, no done_o. busy_o still reflects the state for the flush cycle.
- flush_i in DONE: no effect; the result is already committed.
- flush_i in IDLE: suppresses accept, including MTHI/MTLO.
- reset mid-operation: immediate return to IDLE; HI/LO cleared.
- Undefined op_i values: treated as NOP (no accept, busy_o=0).

Optional Feature:
- Macro: MULDIV_MADD_EN.
- Defined: MADD/MADDU/MSUB/MSUBU are supported.
  - {HI,LO} <= {HI,LO} ± product, modulo 2^64, using the HI/LO value at completion time.
  - Same latency and handshake as MULT.
- Undefined: those four encodings are treated as NOP, and no 64-bit accumulator adder is built.

Decomposition:
- mips.svh package holds:
  - md_op_t enum (NOP, MULT, MULTU, DIV, DIVU, MTHI, MTLO, MADD, MADDU, MSUB, MSUBU);
  - md_state_t enum;
  - DIV_ITERS = 32.
- One sub-module: div_core. It is the iterative restoring divider with start/abort inputs, a done output and magnitude-only operands. muldiv_unit handles sign fix, multiply, FSM and HI/LO.

Test Plan:
- MULT a=0xFFFFFFFD (-3), b=5 -> done_o exactly MUL_LAT+1 edges after accept; HI=0xFFFFFFFF, LO=0xFFFFFFF1; busy_o low in the done cycle.
- DIV a=-7, b=2 -> busy_o high 34 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU with the same operands -> LO=0x7FFFFFFC, HI=1.
- DIVU a=0x1234, b=0 -> LO=0xFFFFFFFF, HI=0x1234. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- MTHI 0xAAAA0000 then MTLO 0x5555 on consecutive cycles -> HI/LO update on each accept edge; busy_o and done_o stay 0.
- DIV started, flush_i at DIV cycle 10 -> IDLE next edge, HI/LO unchanged, no done_o; a following MULTU 0xFFFFFFFF*2 is accepted -> HI=1, LO=0xFFFFFFFE.
- Reset asserted mid-MUL -> outputs zero immediately, asynchronously. With MULDIV_MADD_EN: HI=0, LO=10, then MADD 3*4 -> LO=22; with the macro undefined, the same op -> no busy, HI/LO unchanged.

Source files
------------

// File: rtl/muldiv_unit_pkg.sv
// Shared opcode and state encodings for the HI/LO multiply/divide responder.
package muldiv_unit_pkg;

    typedef enum logic [3:0] {
        NOP   = 4'd0,
        MULT  = 4'd1,
        MULTU = 4'd2,
        DIV   = 4'd3,
        DIVU  = 4'd4,
        MTHI  = 4'd5,
        MTLO  = 4'd6,
        MADD  = 4'd7,
        MADDU = 4'd8,
        MSUB  = 4'd9,
        MSUBU = 4'd10
    } md_op_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_DIV  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } md_state_t;

    localparam int DIV_ITERS = 32;

    function automatic logic is_signed_op(input md_op_t op);
        case (op)
            MULT, DIV, MADD, MSUB: return 1'b1;
            default:               return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/muldiv_unit_div_core.sv
// Iterative radix-2 restoring divider on unsigned magnitudes, one quotient bit per cycle.
module div_core
    import muldiv_unit_pkg::*;
#(
    parameter int W     = 32,
    parameter int ITERS = DIV_ITERS
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         abort,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         done,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder
);

    localparam int CW = $clog2(ITERS);

    logic          run_r;
    logic [CW-1:0] cnt_r;
    logic [W-1:0]  rem_r;
    logic [W-1:0]  quo_r;
    logic [W-1:0]  dvs_r;
    logic [W:0]    shifted_s;
    logic [W-1:0]  diff_s;
    logic [W-1:0]  rem_nxt_s;
    logic [W-1:0]  quo_nxt_s;
    logic          last_s;

    // One restoring step: shift in the next dividend bit and subtract when it fits
    always_comb begin
        shifted_s = {rem_r, quo_r[W-1]};
        diff_s    = shifted_s[W-1:0] - dvs_r;
        if (shifted_s >= {1'b0, dvs_r}) begin
            rem_nxt_s = diff_s;
            quo_nxt_s = {quo_r[W-2:0], 1'b1};
        end else begin
            rem_nxt_s = shifted_s[W-1:0];
            quo_nxt_s = {quo_r[W-2:0], 1'b0};
        end
        last_s = (cnt_r == CW'(ITERS - 1));
    end

    assign done      = run_r && last_s;
    assign quotient  = quo_r;
    assign remainder = rem_r;

    // Iteration state; the final step lands in the same edge that reports done
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_r <= 1'b0;
            cnt_r <= {CW{1'b0}};
            rem_r <= {W{1'b0}};
            quo_r <= {W{1'b0}};
            dvs_r <= {W{1'b0}};
        end else if (abort) begin
            run_r <= 1'b0;
            cnt_r <= {CW{1'b0}};
        end else if (start) begin
            run_r <= 1'b1;
            cnt_r <= {CW{1'b0}};
            rem_r <= {W{1'b0}};
            quo_r <= dividend;
            dvs_r <= divisor;
        end else if (run_r) begin
            rem_r <= rem_nxt_s;
            quo_r <= quo_nxt_s;
            if (last_s) begin
                run_r <= 1'b0;
                cnt_r <= {CW{1'b0}};
            end else begin
                cnt_r <= cnt_r + CW'(1);
            end
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle HI/LO multiply/divide responder owning the architectural HI/LO registers.
// Define MULDIV_MADD_EN to add MADD/MADDU/MSUB/MSUBU accumulation into {HI,LO}.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int MUL_LAT = 2,
    parameter int DATA_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_i,
    input  logic [3:0]        op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic              flush_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    localparam int PW = 2 * DATA_W;

    md_state_t         state_r;
    md_state_t         next_state_s;
    md_op_t            op_s;
    md_op_t            op_r;
    logic [DATA_W-1:0] a_r;
    logic [DATA_W-1:0] b_r;
    logic [DATA_W-1:0] hi_r;
    logic [DATA_W-1:0] lo_r;
    logic [DATA_W-1:0] hi_nxt_s;
    logic [DATA_W-1:0] lo_nxt_s;
    logic              hi_we_s;
    logic              lo_we_s;
    logic              latch_s;
    logic              busy_s;
    logic              done_r;
    logic [2:0]        mul_cnt_r;
    logic              div_start_s;
    logic              div_abort_s;
    logic              div_done_s;
    logic [DATA_W-1:0] div_q_s;
    logic [DATA_W-1:0] div_r_s;
    logic [DATA_W-1:0] mag_a_s;
    logic [DATA_W-1:0] mag_b_s;
    logic              sgn_a_s;
    logic              sgn_b_s;
    logic [DATA_W-1:0] q_fix_s;
    logic [DATA_W-1:0] r_fix_s;
    logic [PW-1:0]     ext_a_s;
    logic [PW-1:0]     ext_b_s;
    logic [PW-1:0]     prod_s;
    logic [PW-1:0]     mul_res_s;

    assign op_s = md_op_t'(op_i);

    // Divider loads magnitudes straight from the inputs so DIV starts on the accept edge
    always_comb begin
        if (is_signed_op(op_s) && a_i[DATA_W-1]) begin
            mag_a_s = -a_i;
        end else begin
            mag_a_s = a_i;
        end
        if (is_signed_op(op_s) && b_i[DATA_W-1]) begin
            mag_b_s = -b_i;
        end else begin
            mag_b_s = b_i;
        end
    end

    div_core #(
        .W     (DATA_W),
        .ITERS (DIV_ITERS)
    ) u_div (
        .clk       (clk),
        .reset     (reset),
        .start     (div_start_s),
        .abort     (div_abort_s),
        .dividend  (mag_a_s),
        .divisor   (mag_b_s),
        .done      (div_done_s),
        .quotient  (div_q_s),
        .remainder (div_r_s)
    );

    // Result datapath from latched operands: product, optional accumulate, divide sign fix
    always_comb begin
        sgn_a_s = is_signed_op(op_r) && a_r[DATA_W-1];
        sgn_b_s = is_signed_op(op_r) && b_r[DATA_W-1];
        ext_a_s = {{DATA_W{sgn_a_s}}, a_r};
        ext_b_s = {{DATA_W{sgn_b_s}}, b_r};
        prod_s  = ext_a_s * ext_b_s;
`ifdef MULDIV_MADD_EN
        case (op_r)
            MADD, MADDU: mul_res_s = {hi_r, lo_r} + prod_s;
            MSUB, MSUBU: mul_res_s = {hi_r, lo_r} - prod_s;
            default:     mul_res_s = prod_s;
        endcase
`else
        mul_res_s = prod_s;
`endif
        q_fix_s = (sgn_a_s ^ sgn_b_s) ? -div_q_s : div_q_s;
        r_fix_s = sgn_a_s ? -div_r_s : div_r_s;
    end

    // FSM next state, stall request and HI/LO write controls
    always_comb begin
        next_state_s = state_r;
        latch_s      = 1'b0;
        busy_s       = 1'b0;
        div_start_s  = 1'b0;
        div_abort_s  = 1'b0;
        hi_we_s      = 1'b0;
        lo_we_s      = 1'b0;
        hi_nxt_s     = hi_r;
        lo_nxt_s     = lo_r;
        case (state_r)
            ST_IDLE: begin
                if (valid_i && !flush_i) begin
                    case (op_s)
                        MULT, MULTU: begin
                            latch_s      = 1'b1;
                            busy_s       = 1'b1;
                            next_state_s = ST_MUL;
                        end
`ifdef MULDIV_MADD_EN
                        MADD, MADDU, MSUB, MSUBU: begin
                            latch_s      = 1'b1;
                            busy_s       = 1'b1;
                            next_state_s = ST_MUL;
                        end
`endif
                        DIV, DIVU: begin
                            latch_s      = 1'b1;
                            busy_s       = 1'b1;
                            div_start_s  = 1'b1;
                            next_state_s = ST_DIV;
                        end
                        MTHI: begin
                            hi_we_s  = 1'b1;
                            hi_nxt_s = a_i;
                        end
                        MTLO: begin
                            lo_we_s  = 1'b1;
                            lo_nxt_s = a_i;
                        end
                        default: begin
                            next_state_s = ST_IDLE;
                        end
                    endcase
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_MUL: begin
                busy_s = 1'b1;
                if (flush_i) begin
                    next_state_s = ST_IDLE;
                end else if (mul_cnt_r == 3'(MUL_LAT - 1)) begin
                    next_state_s = ST_DONE;
                    hi_we_s      = 1'b1;
                    lo_we_s      = 1'b1;
                    hi_nxt_s     = mul_res_s[PW-1:DATA_W];
                    lo_nxt_s     = mul_res_s[DATA_W-1:0];
                end else begin
                    next_state_s = ST_MUL;
                end
            end
            ST_DIV: begin
                busy_s = 1'b1;
                if (flush_i) begin
                    next_state_s = ST_IDLE;
                    div_abort_s  = 1'b1;
                end else if (div_done_s) begin
                    next_state_s = ST_FIX;
                end else begin
                    next_state_s = ST_DIV;
                end
            end
            ST_FIX: begin
                busy_s = 1'b1;
                if (flush_i) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_DONE;
                    hi_we_s      = 1'b1;
                    lo_we_s      = 1'b1;
                    // Zero divisor: no trap, quotient saturates and HI returns the raw dividend
                    if (b_r == {DATA_W{1'b0}}) begin
                        hi_nxt_s = a_r;
                        lo_nxt_s = {DATA_W{1'b1}};
                    end else begin
                        hi_nxt_s = r_fix_s;
                        lo_nxt_s = q_fix_s;
                    end
                end
            end
            ST_DONE: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    assign busy_o = busy_s && !reset;
    assign done_o = done_r;
    assign hi_o   = hi_r;
    assign lo_o   = lo_r;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Operand latches, HI/LO, done pulse and multiply cycle counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_r      <= NOP;
            a_r       <= {DATA_W{1'b0}};
            b_r       <= {DATA_W{1'b0}};
            hi_r      <= {DATA_W{1'b0}};
            lo_r      <= {DATA_W{1'b0}};
            done_r    <= 1'b0;
            mul_cnt_r <= 3'd0;
        end else begin
            if (latch_s) begin
                op_r <= op_s;
                a_r  <= a_i;
                b_r  <= b_i;
            end
            if (hi_we_s) begin
                hi_r <= hi_nxt_s;
            end
            if (lo_we_s) begin
                lo_r <= lo_nxt_s;
            end
            done_r <= (next_state_s == ST_DONE);
            if (state_r == ST_MUL && next_state_s == ST_MUL) begin
                mul_cnt_r <= mul_cnt_r + 3'd1;
            end else begin
                mul_cnt_r <= 3'd0;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized self-checking bench for muldiv_unit against an arithmetic HI/LO reference model.
module tb_muldiv_unit;

    localparam int MUL_LAT = 2;
    localparam int DW      = 32;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MADD  = 4'd7;

    logic          clk;
    logic          reset;
    logic          valid_i;
    logic [3:0]    op_i;
    logic [DW-1:0] a_i;
    logic [DW-1:0] b_i;
    logic          flush_i;
    logic          busy_o;
    logic          done_o;
    logic [DW-1:0] hi_o;
    logic [DW-1:0] lo_o;

    int          n_pass  = 0;
    int          n_total = 0;
    logic [31:0] m_hi    = 32'h0;
    logic [31:0] m_lo    = 32'h0;

    muldiv_unit #(
        .MUL_LAT (MUL_LAT),
        .DATA_W  (DW)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .valid_i (valid_i),
        .op_i    (op_i),
        .a_i     (a_i),
        .b_i     (b_i),
        .flush_i (flush_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .hi_o    (hi_o),
        .lo_o    (lo_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // 0 = ignored, 1 = move to HI/LO, 2 = multiply class, 3 = divide class
    function automatic int op_kind(input logic [3:0] op);
        case (op)
            4'd1, 4'd2: return 2;
            4'd3, 4'd4: return 3;
            4'd5, 4'd6: return 1;
`ifdef MULDIV_MADD_EN
            4'd7, 4'd8, 4'd9, 4'd10: return 2;
`endif
            default: return 0;
        endcase
    endfunction

    function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] hi,
                                          input logic [31:0] lo);
        logic [63:0] sp;
        logic [63:0] up;
        logic [63:0] acc;
        longint      la;
        longint      lb;
        int          sa;
        int          sb;
        la  = longint'($signed(a));
        lb  = longint'($signed(b));
        sp  = la * lb;
        up  = {32'h0, a} * {32'h0, b};
        acc = {hi, lo};
        if (op_kind(op) == 0) return acc;
        case (op)
            4'd1: return sp;
            4'd2: return up;
            4'd3: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                sa = $signed(a);
                sb = $signed(b);
                return {32'(sa % sb), 32'(sa / sb)};
            end
            4'd4: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            4'd5:  return {a, lo};
            4'd6:  return {hi, a};
            4'd7:  return acc + sp;
            4'd8:  return acc + up;
            4'd9:  return acc - sp;
            4'd10: return acc - up;
            default: return acc;
        endcase
    endfunction

    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int          kind;
        int          cycles;
        int          busy_cnt;
        int          exp_lat;
        logic [63:0] exp;
        kind    = op_kind(op);
        exp     = model(op, a, b, m_hi, m_lo);
        exp_lat = (kind == 3) ? 34 : MUL_LAT + 1;
        @(negedge clk);
        valid_i = 1'b1;
        op_i    = op;
        a_i     = a;
        b_i     = b;
        #1;
        check_eq("busy_accept", busy_o, (kind >= 2) ? 64'd1 : 64'd0);
        @(negedge clk);
        valid_i = 1'b0;
        op_i    = OP_NOP;
        if (kind < 2) begin
            check_eq("done_nomd", done_o, 64'd0);
            check_eq("busy_nomd", busy_o, 64'd0);
        end else begin
            cycles   = 1;
            busy_cnt = 1;
            while (!done_o && cycles < 100) begin
                if (busy_o) busy_cnt++;
                @(negedge clk);
                cycles++;
            end
            check_eq("latency", cycles, exp_lat);
            check_eq("busy_cycles", busy_cnt, exp_lat);
            check_eq("busy_in_done", busy_o, 64'd0);
        end
        check_eq("hi", hi_o, exp[63:32]);
        check_eq("lo", lo_o, exp[31:0]);
        if (kind >= 2) begin
            @(negedge clk);
            check_eq("done_pulse", done_o, 64'd0);
        end
        m_hi = exp[63:32];
        m_lo = exp[31:0];
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int          seen;
        logic [3:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;

        reset   = 1'b1;
        valid_i = 1'b1;
        op_i    = OP_MULT;
        a_i     = 32'h1234_5678;
        b_i     = 32'h9;
        flush_i = 1'b0;
        #12;
        check_eq("rst_busy", busy_o, 64'd0);
        check_eq("rst_done", done_o, 64'd0);
        check_eq("rst_hi", hi_o, 64'd0);
        check_eq("rst_lo", lo_o, 64'd0);
        @(negedge clk);
        reset   = 1'b0;
        valid_i = 1'b0;
        op_i    = OP_NOP;

        run_op(OP_MULT, 32'hFFFF_FFFD, 32'd5);
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        run_op(OP_DIVU, 32'hFFFF_FFF9, 32'd2);
        run_op(OP_DIVU, 32'h0000_1234, 32'd0);
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);

        // MTHI then MTLO on consecutive cycles
        @(negedge clk);
        valid_i = 1'b1;
        op_i    = OP_MTHI;
        a_i     = 32'hAAAA_0000;
        #1;
        check_eq("mthi_busy", busy_o, 64'd0);
        @(negedge clk);
        op_i = OP_MTLO;
        a_i  = 32'h0000_5555;
        check_eq("mthi_hi", hi_o, 64'hAAAA_0000);
        check_eq("mthi_done", done_o, 64'd0);
        check_eq("mtlo_busy", busy_o, 64'd0);
        @(negedge clk);
        valid_i = 1'b0;
        op_i    = OP_NOP;
        check_eq("mtlo_lo", lo_o, 64'h5555);
        check_eq("mtlo_done", done_o, 64'd0);
        m_hi = 32'hAAAA_0000;
        m_lo = 32'h0000_5555;

        // Flush in IDLE suppresses a move
        @(negedge clk);
        valid_i = 1'b1;
        op_i    = OP_MTHI;
        a_i     = 32'hDEAD_BEEF;
        flush_i = 1'b1;
        #1;
        check_eq("idleflush_busy", busy_o, 64'd0);
        @(negedge clk);
        valid_i = 1'b0;
        flush_i = 1'b0;
        op_i    = OP_NOP;
        check_eq("idleflush_hi", hi_o, m_hi);

        // Flush at DIV cycle 10 abandons the divide
        @(negedge clk);
        valid_i = 1'b1;
        op_i    = OP_DIV;
        a_i     = 32'd100;
        b_i     = 32'd7;
        @(negedge clk);
        valid_i = 1'b0;
        op_i    = OP_NOP;
        repeat (10) @(negedge clk);
        flush_i = 1'b1;
        #1;
        check_eq("divflush_busy", busy_o, 64'd1);
        @(negedge clk);
        flush_i = 1'b0;
        check_eq("divflush_idle_busy", busy_o, 64'd0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done_o) seen++;
        end
        check_eq("divflush_no_done", seen, 64'd0);
        check_eq("divflush_hi", hi_o, m_hi);
        check_eq("divflush_lo", lo_o, m_lo);
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'd2);

        for (int i = 0; i < 40; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'h0;
                1: rb = 32'hFFFF_FFFF;
                2: rb = $urandom_range(1, 20);
                3: ra = $urandom_range(0, 1000);
                default: ra = ra;
            endcase
            run_op(rop, ra, rb);
        end

        // Reset arriving mid-multiply clears everything without a clock edge
        run_op(OP_MTHI, 32'h1357_9BDF, 32'h0);
        @(negedge clk);
        valid_i = 1'b1;
        op_i    = OP_MULT;
        a_i     = 32'd7;
        b_i     = 32'd9;
        @(negedge clk);
        valid_i = 1'b0;
        op_i    = OP_NOP;
        #2;
        reset = 1'b1;
        #1;
        check_eq("midrst_hi", hi_o, 64'd0);
        check_eq("midrst_lo", lo_o, 64'd0);
        check_eq("midrst_busy", busy_o, 64'd0);
        check_eq("midrst_done", done_o, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        m_hi  = 32'h0;
        m_lo  = 32'h0;
        seen  = 0;
        repeat (5) begin
            @(negedge clk);
            if (done_o) seen++;
        end
        check_eq("midrst_no_done", seen, 64'd0);

        run_op(OP_MTHI, 32'h0, 32'h0);
        run_op(OP_MTLO, 32'd10, 32'h0);
        run_op(OP_MADD, 32'd3, 32'd4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
